mult_arbiter: RTL and testbench
===============================

MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 Parameter NUM_CH, default 2, number of requester channels (2..8).
REQ-002 Parameter QBITS, default 10, fixed-point fraction bits removed after multiply.
REQ-003 clock  input  1  single clock, all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 ch_enable  input  NUM_CH  per-channel grant mask; a 0 bit excludes that channel from arbitration.
REQ-006 inA_rd_en  output  NUM_CH  pop strobe to each channel's operand-A FIFO.
REQ-007 inA_empty  input  NUM_CH  operand-A FIFO empty flags.
REQ-008 inA_dout  input  NUM_CH x 32 signed  operand-A FIFO head data; first-word-fall-through.
REQ-009 inB_rd_en / inB_empty / inB_dout  same widths and meaning as REQ-006..008, for operand B.
REQ-010 out_wr_en  output  NUM_CH  push strobe to each channel's result FIFO.
REQ-011 out_full  input  NUM_CH  result FIFO full flags.
REQ-012 out_din  output  NUM_CH x 32 signed  result data per channel.
REQ-013 busy  output  1  high whenever state is not IDLE.
REQ-014 grant_ch  output  clog2(NUM_CH)  channel index of the current or most recent grant.

Function
REQ-015 The block SHALL share one registered 32x32 signed multiplier among NUM_CH channels.
REQ-016 Eligibility: channel i is eligible iff ch_enable[i]=1, inA_empty[i]=0, inB_empty[i]=0 and out_full[i]=0, all sampled in the same cycle.
REQ-017 States SHALL be IDLE and WRITE; any illegal encoding SHALL return to IDLE on the next edge.
REQ-018 IDLE with no eligible channel: hold state; all strobes 0.
REQ-019 IDLE with at least one eligible channel: select the winner by round-robin, searching from (last_grant+1) mod NUM_CH upward with wrap-around.
REQ-020 Grant cycle: assert inA_rd_en[w] and inB_rd_en[w] together for exactly one cycle, and no other rd_en bit.
REQ-021 Grant cycle: register product = (inA_dout[w] * inB_dout[w]) computed at 64 bits, arithmetically shifted right by QBITS, low 32 bits kept; the shift rounds toward negative infinity and overflow wraps without saturation.
REQ-022 Grant cycle: update last_grant and grant_ch to w; go to WRITE.
REQ-023 WRITE with out_full[w]=0: assert out_wr_en[w] for one cycle with out_din[w]=product; go to IDLE.
REQ-024 WRITE with out_full[w]=1: hold WRITE with out_wr_en=0 and the product retained until out_full[w]=0.
REQ-025 Latency: the result is written 1 cycle after the pop; maximum throughput is 1 result per 2 cycles.
REQ-026 out_din[i] SHALL be 0 except for channel w during its write cycle.
REQ-027 ch_enable changes SHALL affect only the next arbitration; an in-flight grant SHALL complete.
REQ-028 A single eligible channel SHALL be granted repeatedly; a grant SHALL never pop a channel whose A or B FIFO is empty.
REQ-029 Channels SHALL never starve: with all channels continuously eligible, grants rotate 0,1,..,NUM_CH-1,0.

Reset
REQ-030 Reset asserted SHALL immediately force: state IDLE, product 0, last_grant NUM_CH-1 (so channel 0 wins first), grant_ch 0, all rd_en/wr_en 0, out_din 0, busy 0.
REQ-031 Reset during WRITE SHALL discard the pending product; the popped operands are lost and no write occurs.
REQ-032 Reset deassertion SHALL take effect on the first rising clock edge after release; arbitration starts in that cycle.

Verification
REQ-033 Ch0 A=2048, B=3072 (2.0 x 3.0), other channels empty -> one pop on ch0, next cycle out_wr_en[0]=1 with out_din[0]=6144.
REQ-034 A=-1024, B=1536 -> -1536; A=-1, B=1 -> -1 (floor rounding check).
REQ-035 Both channels always eligible with 4 operand pairs each -> grant order 0,1,0,1,0,1,0,1 and 8 writes in 16 cycles.
REQ-036 Ch1 granted, out_full[1] raised in WRITE for 3 cycles -> busy=1, no writes, product held; single write on the first cycle out_full[1]=0.
REQ-037 ch_enable=01 with both channels loaded -> only ch0 granted; set ch_enable=11 -> ch1 granted at the next arbitration.
REQ-038 Drive reset=0 in WRITE -> outputs 0 immediately and no write; after release with ch0 and ch1 eligible, ch0 is granted first.

Source files
------------

// File: rtl/mult_arbiter.sv
// mult_arbiter: one registered 32x32 signed fixed-point multiplier shared
// round-robin among NUM_CH channels.
//   clock, reset         : rising-edge clock, asynchronous active-low reset
//   ch_enable            : per-channel arbitration mask
//   inA_* / inB_*        : first-word-fall-through operand FIFO interfaces
//   out_wr_en/out_full/out_din : result FIFO interfaces (32 bits per channel)
//   busy                 : a grant is in flight (not IDLE)
//   grant_ch             : channel of the current or most recent grant
module mult_arbiter #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned QBITS  = 10,
  localparam int unsigned GW    = $clog2(NUM_CH)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_CH-1:0]      ch_enable,
  output logic [NUM_CH-1:0]      inA_rd_en,
  input  logic [NUM_CH-1:0]      inA_empty,
  input  logic [NUM_CH*32-1:0]   inA_dout,
  output logic [NUM_CH-1:0]      inB_rd_en,
  input  logic [NUM_CH-1:0]      inB_empty,
  input  logic [NUM_CH*32-1:0]   inB_dout,
  output logic [NUM_CH-1:0]      out_wr_en,
  input  logic [NUM_CH-1:0]      out_full,
  output logic [NUM_CH*32-1:0]   out_din,
  output logic                   busy,
  output logic [GW-1:0]          grant_ch
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WRITE = 2'b01
  } state_t;

  state_t             state, state_nxt;
  logic [31:0]        product, product_nxt;
  logic [GW-1:0]      last_grant, last_grant_nxt;
  logic [GW-1:0]      grant_ch_nxt;
  logic [NUM_CH-1:0]  eligible;
  logic [GW-1:0]      winner;
  logic               found;
  logic signed [31:0] a_sel, b_sel;
  logic signed [63:0] full_prod;

  assign eligible = ch_enable & ~inA_empty & ~inB_empty & ~out_full;
  assign busy     = (state != IDLE);

  // Round-robin search starting one past the last grant, wrapping around.
  always_comb begin
    int unsigned idx;
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int unsigned k = 1; k <= NUM_CH; k++) begin
      idx = 32'(last_grant) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!found && eligible[GW'(idx)]) begin
        found  = 1'b1;
        winner = GW'(idx);
      end
    end
  end

  always_comb begin
    a_sel     = inA_dout[32*winner +: 32];
    b_sel     = inB_dout[32*winner +: 32];
    full_prod = 64'(a_sel) * 64'(b_sel);
  end

  always_comb begin
    state_nxt      = state;
    product_nxt    = product;
    last_grant_nxt = last_grant;
    grant_ch_nxt   = grant_ch;
    inA_rd_en      = '0;
    inB_rd_en      = '0;
    out_wr_en      = '0;
    out_din        = '0;
    case (state)
      IDLE: begin
        // Gated by reset so no pop strobe escapes while reset is held.
        if (found && reset) begin
          inA_rd_en[winner] = 1'b1;
          inB_rd_en[winner] = 1'b1;
          product_nxt       = 32'(full_prod >>> QBITS);
          last_grant_nxt    = winner;
          grant_ch_nxt      = winner;
          state_nxt         = WRITE;
        end
      end
      WRITE: begin
        if (!out_full[grant_ch]) begin
          out_wr_en[grant_ch]          = 1'b1;
          out_din[32*grant_ch +: 32]   = product;
          state_nxt                    = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      product    <= '0;
      last_grant <= GW'(NUM_CH - 1);
      grant_ch   <= '0;
    end else begin
      state      <= state_nxt;
      product    <= product_nxt;
      last_grant <= last_grant_nxt;
      grant_ch   <= grant_ch_nxt;
    end
  end

endmodule

// File: tb/tb_mult_arbiter.sv
module tb_mult_arbiter;

  localparam int NUM_CH = 2;
  localparam int QBITS  = 10;
  localparam int GW     = $clog2(NUM_CH);

  logic                  clock = 1'b0;
  logic                  reset;
  logic [NUM_CH-1:0]     ch_enable;
  logic [NUM_CH-1:0]     inA_rd_en, inA_empty;
  logic [NUM_CH*32-1:0]  inA_dout;
  logic [NUM_CH-1:0]     inB_rd_en, inB_empty;
  logic [NUM_CH*32-1:0]  inB_dout;
  logic [NUM_CH-1:0]     out_wr_en, out_full;
  logic [NUM_CH*32-1:0]  out_din;
  logic                  busy;
  logic [GW-1:0]         grant_ch;

  int checks   = 0;
  int failures = 0;

  // Operand FIFO contents per channel (head = element 0).
  int qa[NUM_CH][$];
  int qb[NUM_CH][$];

  // Transaction-level reference state.
  bit          pend;
  int          pend_ch;
  logic [31:0] pend_val;
  int          last_g;
  int          exp_gch;
  int          cycle;

  // Observed activity logs.
  int          grant_log[$];
  int          grant_cyc[$];
  int          wr_ch[$];
  logic [31:0] wr_val[$];
  int          wr_cyc[$];

  always #5 clock = ~clock;

  mult_arbiter #(.NUM_CH(NUM_CH), .QBITS(QBITS)) dut (
    .clock     (clock),
    .reset     (reset),
    .ch_enable (ch_enable),
    .inA_rd_en (inA_rd_en),
    .inA_empty (inA_empty),
    .inA_dout  (inA_dout),
    .inB_rd_en (inB_rd_en),
    .inB_empty (inB_empty),
    .inB_dout  (inB_dout),
    .out_wr_en (out_wr_en),
    .out_full  (out_full),
    .out_din   (out_din),
    .busy      (busy),
    .grant_ch  (grant_ch)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Fixed-point product: exact 64-bit product divided by 2^QBITS, rounded
  // toward negative infinity, low 32 bits kept.
  function automatic logic [31:0] ref_mul(input int a, input int b);
    longint p, d, q;
    p = longint'(a) * longint'(b);
    d = longint'(1) << QBITS;
    q = p / d;
    if (p < 0 && (p % d) != 0) q = q - 1;
    return q[31:0];
  endfunction

  function automatic bit elig(input int c);
    return ch_enable[c] && qa[c].size() != 0 && qb[c].size() != 0 && !out_full[c];
  endfunction

  function automatic int rand_op();
    if ($urandom_range(0, 1) == 0) return int'($urandom);
    return int'($urandom_range(0, 8191)) - 4096;
  endfunction

  task automatic drive_fifos();
    for (int i = 0; i < NUM_CH; i++) begin
      inA_empty[i]        = (qa[i].size() == 0);
      inB_empty[i]        = (qb[i].size() == 0);
      inA_dout[i*32 +: 32] = (qa[i].size() != 0) ? qa[i][0] : 32'h0;
      inB_dout[i*32 +: 32] = (qb[i].size() != 0) ? qb[i][0] : 32'h0;
    end
  endtask

  task automatic clear_logs();
    grant_log.delete(); grant_cyc.delete();
    wr_ch.delete(); wr_val.delete(); wr_cyc.delete();
  endtask

  task automatic load(input int ch, input int a, input int b);
    qa[ch].push_back(a);
    qb[ch].push_back(b);
  endtask

  // One clock cycle: compare at the falling edge, update FIFOs after the rising edge.
  task automatic step();
    int w;
    int c;
    logic [NUM_CH-1:0]    exp_rd;
    logic [NUM_CH-1:0]    exp_wr;
    logic [NUM_CH*32-1:0] exp_din;
    w = -1;
    @(negedge clock);
    if (!reset) begin
      chk("rst_busy",  64'(busy),      64'(0));
      chk("rst_rd_a",  64'(inA_rd_en), 64'(0));
      chk("rst_rd_b",  64'(inB_rd_en), 64'(0));
      chk("rst_wr",    64'(out_wr_en), 64'(0));
      chk("rst_din",   64'(out_din),   64'(0));
      chk("rst_gch",   64'(grant_ch),  64'(0));
    end else if (pend) begin
      exp_wr  = '0;
      exp_din = '0;
      if (!out_full[pend_ch]) begin
        exp_wr[pend_ch]            = 1'b1;
        exp_din[pend_ch*32 +: 32]  = pend_val;
      end
      chk("wr_rd_a",  64'(inA_rd_en), 64'(0));
      chk("wr_rd_b",  64'(inB_rd_en), 64'(0));
      chk("wr_busy",  64'(busy),      64'(1));
      chk("wr_gch",   64'(grant_ch),  64'(pend_ch));
      chk("wr_en",    64'(out_wr_en), 64'(exp_wr));
      chk("wr_din",   64'(out_din),   64'(exp_din));
      if (!out_full[pend_ch]) pend = 1'b0;
    end else begin
      chk("idle_busy", 64'(busy),      64'(0));
      chk("idle_wr",   64'(out_wr_en), 64'(0));
      chk("idle_din",  64'(out_din),   64'(0));
      chk("idle_gch",  64'(grant_ch),  64'(exp_gch));
      for (int k = 1; k <= NUM_CH; k++) begin
        c = (last_g + k) % NUM_CH;
        if (w < 0 && elig(c)) w = c;
      end
      exp_rd = '0;
      if (w >= 0) exp_rd[w] = 1'b1;
      chk("grant_rd_a", 64'(inA_rd_en), 64'(exp_rd));
      chk("grant_rd_b", 64'(inB_rd_en), 64'(exp_rd));
      if (w >= 0) begin
        pend     = 1'b1;
        pend_ch  = w;
        pend_val = ref_mul(qa[w][0], qb[w][0]);
        last_g   = w;
        exp_gch  = w;
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (inA_rd_en[i]) begin grant_log.push_back(i); grant_cyc.push_back(cycle); end
      if (out_wr_en[i]) begin
        wr_ch.push_back(i);
        wr_val.push_back(out_din[i*32 +: 32]);
        wr_cyc.push_back(cycle);
      end
    end
    @(posedge clock);
    #1;
    if (w >= 0) begin
      void'(qa[w].pop_front());
      void'(qb[w].pop_front());
    end
    cycle++;
    drive_fifos();
  endtask

  task automatic do_reset(input int n);
    reset   = 1'b0;
    pend    = 1'b0;
    last_g  = NUM_CH - 1;
    exp_gch = 0;
    repeat (n) step();
    reset = 1'b1;
    drive_fifos();
  endtask

  initial begin
    int a, b;
    reset     = 1'b0;
    ch_enable = '1;
    out_full  = '0;
    pend      = 1'b0;
    last_g    = NUM_CH - 1;
    exp_gch   = 0;
    cycle     = 0;
    load(0, 2048, 3072);
    drive_fifos();
    #1;
    chk("rst0_busy", 64'(busy),      64'(0));
    chk("rst0_rd",   64'(inA_rd_en), 64'(0));
    chk("rst0_wr",   64'(out_wr_en), 64'(0));
    chk("rst0_gch",  64'(grant_ch),  64'(0));

    // 2.0 x 3.0 on ch0, written one cycle after the pop.
    do_reset(2);
    clear_logs();
    repeat (4) step();
    chk("s0_ngrant",  64'(grant_log.size()), 64'(1));
    chk("s0_gch",     64'(grant_log[0]),     64'(0));
    chk("s0_nwr",     64'(wr_val.size()),    64'(1));
    chk("s0_val",     64'(wr_val[0]),        64'(6144));
    chk("s0_latency", 64'(wr_cyc[0] - grant_cyc[0]), 64'(1));

    // Floor rounding on negative products; single channel granted repeatedly.
    clear_logs();
    load(0, -1024, 1536);
    load(0, -1, 1);
    drive_fifos();
    repeat (6) step();
    chk("s1_nwr",  64'(wr_val.size()), 64'(2));
    chk("s1_neg",  64'(wr_val[0]),     64'(32'hFFFF_FA00));
    chk("s1_floor",64'(wr_val[1]),     64'(32'hFFFF_FFFF));

    // Both channels continuously eligible: strict alternation, 8 writes in 16 cycles.
    clear_logs();
    for (int i = 0; i < 4; i++) begin
      load(0, rand_op(), rand_op());
      load(1, rand_op(), rand_op());
    end
    drive_fifos();
    do_reset(1);
    clear_logs();
    repeat (16) step();
    chk("s2_nwr",    64'(wr_val.size()),    64'(8));
    chk("s2_ngrant", 64'(grant_log.size()), 64'(8));
    for (int i = 0; i < 8; i++) chk("s2_order", 64'(grant_log[i]), 64'(i % 2));

    // Back-pressure on ch1 during WRITE for three cycles.
    clear_logs();
    a = rand_op();
    b = rand_op();
    load(1, a, b);
    drive_fifos();
    step();
    out_full[1] = 1'b1;
    repeat (3) step();
    chk("s3_held_nwr", 64'(wr_val.size()), 64'(0));
    chk("s3_busy",     64'(busy),          64'(1));
    out_full[1] = 1'b0;
    step();
    chk("s3_nwr",  64'(wr_val.size()), 64'(1));
    chk("s3_val",  64'(wr_val[0]),     64'(ref_mul(a, b)));
    chk("s3_when", 64'(wr_cyc[0] - grant_cyc[0]), 64'(4));

    // Masked channel is skipped until re-enabled.
    clear_logs();
    ch_enable = 2'b01;
    for (int i = 0; i < 4; i++) load(0, rand_op(), rand_op());
    for (int i = 0; i < 2; i++) load(1, rand_op(), rand_op());
    drive_fifos();
    repeat (6) step();
    chk("s4_ngrant", 64'(grant_log.size()), 64'(3));
    chk("s4_only0",  64'(grant_log.sum()),  64'(0));
    ch_enable = 2'b11;
    step();
    chk("s4_ch1", 64'(grant_log[grant_log.size()-1]), 64'(1));
    repeat (8) step();

    // Reset while ch1 waits in WRITE: immediate clear, product discarded.
    clear_logs();
    load(0, rand_op(), rand_op()); load(0, rand_op(), rand_op());
    load(1, rand_op(), rand_op()); load(1, rand_op(), rand_op());
    drive_fifos();
    repeat (3) step();
    chk("s5_inwrite", 64'(busy), 64'(1));
    reset = 1'b0;
    #1;
    chk("s5_wr",   64'(out_wr_en), 64'(0));
    chk("s5_din",  64'(out_din),   64'(0));
    chk("s5_busy", 64'(busy),      64'(0));
    chk("s5_gch",  64'(grant_ch),  64'(0));
    pend    = 1'b0;
    last_g  = NUM_CH - 1;
    exp_gch = 0;
    repeat (2) step();
    reset = 1'b1;
    drive_fifos();
    clear_logs();
    repeat (6) step();
    chk("s5_first", 64'(grant_log[0]),  64'(0));
    chk("s5_nwr",   64'(wr_val.size()), 64'(2));

    // Randomized traffic, back-pressure and masking against the reference.
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if ($urandom_range(0, 3) == 0 && qa[i].size() < 4) qa[i].push_back(rand_op());
        if ($urandom_range(0, 3) == 0 && qb[i].size() < 4) qb[i].push_back(rand_op());
        out_full[i] = ($urandom_range(0, 4) == 0);
      end
      if ($urandom_range(0, 9) == 0) ch_enable = NUM_CH'($urandom_range(0, (1 << NUM_CH) - 1));
      drive_fifos();
      step();
    end
    ch_enable = '1;
    out_full  = '0;
    drive_fifos();
    repeat (20) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
